operand_fwd_unit: RTL and testbench
===================================

Name: operand_fwd_unit

Overview:
- Parametrised operand-select and bypass unit for the RISC-V core. Replaces the fixed 4-input A-operand mux.
- Keeps a DEPTH-entry history of recent writebacks (rd, data, load-pending flag).
- Drives both ALU operands (A and B) from the youngest matching in-flight result, or from the register file, PC or immediate.
- Raises a load-use stall when the youngest match is a load whose data has not returned yet.

Parameters:
- XLEN, 32, datapath width.
- DEPTH, 3, number of history entries; writes DEPTH or more pushes old are visible in the write-first register file.
- FWD_EN, 1, 1 = bypass enabled; 0 = interlock-only mode (any pending-hazard match stalls; the register file is always used).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- adv  in  1  pipeline advance; push and shift history this cycle
- wb_valid  in  1  pushed instruction writes a register
- wb_rd  in  5  destination register of pushed instruction
- wb_data  in  XLEN  result of pushed instruction (ignored if wb_is_load)
- wb_is_load  in  1  pushed entry is a load; data arrives later
- ld_resp_valid  in  1  load data returning
- ld_resp_data  in  XLEN  returned load data
- rs1, rs2  in  5 each  source registers of the consumer
- rf_data_a, rf_data_b  in  XLEN each  register file read data
- pc, imm  in  XLEN each  alternate operand sources
- a_use_pc  in  1  1 = A from pc, otherwise rs1 path
- b_use_imm  in  1  1 = B from imm, otherwise rs2 path
- a_out, b_out  out  XLEN each  selected operands
- stall  out  1  load-use or interlock stall request
- fwd_err  out  1  sticky; a pending load entry aged out of the history

Behaviour:
- History: entries 0..DEPTH-1; entry 0 is the youngest. Fields per entry: vld, rd, data, pend.
- Reset: all vld=0, pend=0, data=0, fwd_err=0.
  - After reset a_out=rf_data_a (or pc) and b_out=rf_data_b (or imm), purely combinational; stall=0.
- Push when adv=1:
  - entry k+1 <= entry k; entry DEPTH-1 is discarded.
  - entry 0 <= {wb_valid && wb_rd!=0, wb_rd, wb_data, wb_is_load && wb_valid && wb_rd!=0}.
  - When adv=0 the history holds.
- Load fill when ld_resp_valid=1:
  - Target is the oldest entry with pend=1, evaluated on pre-shift state.
  - Target gets data=ld_resp_data and pend=0.
  - If a push happens in the same cycle, the filled values land at the target's post-shift index (k+1). The new entry 0 is never filled in its push cycle.
  - A fill with no pending entry is ignored.
- Aging error: if adv=1 and entry DEPTH-1 has pend=1 with no fill targeting it this cycle, fwd_err <= 1. fwd_err clears only on rst.
- Match for operand X (rs1 for A, rs2 for B):
  - Candidate entries have vld=1 and rd==rsX; rsX==0 never matches.
  - The lowest index wins (youngest first).
- FWD_EN=1, A path (a_use_pc=0):
  - Youngest match with pend=0 -> a_out = entry data.
  - Youngest match with pend=1 -> stall contribution; a_out = rf_data_a (don't-care value, but deterministic).
  - No match -> a_out = rf_data_a.
- FWD_EN=1, B path: same rules with rs2, rf_data_b, b_use_imm.
- FWD_EN=0:
  - Operands always come from rf_data/pc/imm.
  - Any match (pend or not) on a used operand contributes stall.
- Operand use:
  - a_use_pc=1 -> a_out=pc, and A contributes no stall.
  - b_use_imm=1 -> b_out=imm, and B contributes no stall.
- stall = OR of the A and B contributions. It is combinational from the history and current inputs, with no registered delay.
  - The core pushes a bubble (wb_valid=0) with adv=1 while stalled.
  - The block does not gate adv internally.
- Data from an entry that was filled this cycle is visible from the next cycle; no same-cycle bypass of ld_resp_data.
- Latency: zero-cycle combinational select; history update 1 cycle after push.

Test Plan:
- Reset, then rs1=5, rf_data_a=0x11: a_out=0x11, stall=0, fwd_err=0.
- Two pushes: push rd=5 data=0xAAAA, then push rd=5 data=0xBBBB, with rs1=5 -> a_out=0xBBBB (youngest wins). Push rd=0 data=0xCC, rs2=0, rf_data_b=0 -> b_out=0 (x0 never forwarded).
- Load-use:
  - Push load rd=7, then rs2=7 -> stall=1.
  - Push bubble with ld_resp_valid=1, data=0x1234 in the same cycle.
  - Next cycle: stall=0, b_out=0x1234.
- Operand select:
  - a_use_pc=1, pc=0x1000, rs1 matching a pending load -> a_out=0x1000, stall=0.
  - b_use_imm=1 -> b_out=imm.
- Aging and adv=0 (DEPTH=3):
  - Push a load rd=9, then 3 pushes with no response -> fwd_err=1 and stays 1 until rst.
  - With adv=0 for 4 cycles, a history entry with rd=4 data=0x55 keeps forwarding 0x55.
- FWD_EN=0:
  - A non-pending match on rs1 -> stall=1 and a_out=rf_data_a.
  - After DEPTH bubble pushes -> stall=0.

Source files
------------

// File: rtl/operand_fwd_unit.sv
// Operand select and bypass unit: keeps a short writeback history and drives
// both ALU operands from the youngest in-flight result, raising load-use stalls.
module operand_fwd_unit #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 3,
  parameter bit FWD_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            adv,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_is_load,
  input  logic            ld_resp_valid,
  input  logic [XLEN-1:0] ld_resp_data,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  input  logic [XLEN-1:0] rf_data_a,
  input  logic [XLEN-1:0] rf_data_b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            a_use_pc,
  input  logic            b_use_imm,
  output logic [XLEN-1:0] a_out,
  output logic [XLEN-1:0] b_out,
  output logic            stall,
  output logic            fwd_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] h_vld;
  logic [DEPTH-1:0] h_pend;
  logic [4:0]       h_rd   [DEPTH];
  logic [XLEN-1:0]  h_data [DEPTH];

  logic          wb_en;
  logic          fill_hit;
  logic [IW-1:0] fill_idx;
  logic          a_hit, b_hit;
  logic [IW-1:0] a_idx, b_idx;
  logic          a_fwd, b_fwd;
  logic          a_stall, b_stall;

  // x0 is hard-wired zero, so a write to it never enters the history as valid.
  assign wb_en = wb_valid && (wb_rd != 5'd0);

  // Oldest pending entry takes the returning load data (loads complete in order).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fill_hit = 1'b0;
    fill_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ld_resp_valid && h_pend[k]) begin
        fill_hit = 1'b1;
        fill_idx = IW'(k);
      end
    end
  end

  // Scan oldest to youngest so the youngest match overwrites earlier hits.
  always_comb begin
    a_hit = 1'b0;
    a_idx = '0;
    b_hit = 1'b0;
    b_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (h_vld[k] && (h_rd[k] == rs1) && (rs1 != 5'd0)) begin
        a_hit = 1'b1;
        a_idx = IW'(k);
      end
      if (h_vld[k] && (h_rd[k] == rs2) && (rs2 != 5'd0)) begin
        b_hit = 1'b1;
        b_idx = IW'(k);
      end
    end
  end

  // In interlock-only mode any match on a used operand stalls and nothing is bypassed.
  assign a_fwd   = FWD_EN && a_hit && !h_pend[a_idx];
  assign b_fwd   = FWD_EN && b_hit && !h_pend[b_idx];
  assign a_stall = !a_use_pc  && a_hit && (!FWD_EN || h_pend[a_idx]);
  assign b_stall = !b_use_imm && b_hit && (!FWD_EN || h_pend[b_idx]);

  assign a_out = a_use_pc  ? pc  : (a_fwd ? h_data[a_idx] : rf_data_a);
  assign b_out = b_use_imm ? imm : (b_fwd ? h_data[b_idx] : rf_data_b);
  assign stall = a_stall || b_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the history is a handful of flops and its data is reset too, so
      // operands never carry X after reset; large RAMs would not be reset this way.
      for (int k = 0; k < DEPTH; k++) begin
        h_vld[k]  <= 1'b0;
        h_pend[k] <= 1'b0;
        h_rd[k]   <= 5'd0;
        h_data[k] <= '0;
      end
      fwd_err <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let every entry shift from pre-edge values.
      for (int k = 1; k < DEPTH; k++) begin
        h_vld[k] <= h_vld[k-1];
        h_rd[k]  <= h_rd[k-1];
        if (fill_hit && (fill_idx == IW'(k - 1))) begin
          h_data[k] <= ld_resp_data;
          h_pend[k] <= 1'b0;
        end else begin
          h_data[k] <= h_data[k-1];
          h_pend[k] <= h_pend[k-1];
        end
      end
      h_vld[0]  <= wb_en;
      h_rd[0]   <= wb_rd;
      h_data[0] <= wb_data;
      h_pend[0] <= wb_en && wb_is_load;
      // A load still waiting when it leaves the history can never be bypassed.
      if (h_pend[DEPTH-1] && !(fill_hit && (fill_idx == IW'(DEPTH - 1))))
        fwd_err <= 1'b1;
    end else if (fill_hit) begin
      h_data[fill_idx] <= ld_resp_data;
      h_pend[fill_idx] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Bench for operand_fwd_unit: bypass and interlock-only instances share stimulus
// and are compared against a queue-based history model.
module tb_operand_fwd_unit;

  localparam int XLEN  = 32;
  localparam int DEPTH = 3;

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        pend;
  } ent_t;

  logic clk = 1'b0;
  logic rst, adv, wb_valid, wb_is_load, ld_resp_valid, a_use_pc, b_use_imm;
  logic [4:0] wb_rd, rs1, rs2;
  logic [XLEN-1:0] wb_data, ld_resp_data, rf_data_a, rf_data_b, pc, imm;
  logic [XLEN-1:0] a_out, b_out, a_out_nf, b_out_nf;
  logic stall, fwd_err, stall_nf, fwd_err_nf;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t hq[$];
  logic m_err;

  always #5 clk = ~clk;

  operand_fwd_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .FWD_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .adv(adv), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_is_load(wb_is_load), .ld_resp_valid(ld_resp_valid),
    .ld_resp_data(ld_resp_data), .rs1(rs1), .rs2(rs2), .rf_data_a(rf_data_a),
    .rf_data_b(rf_data_b), .pc(pc), .imm(imm), .a_use_pc(a_use_pc),
    .b_use_imm(b_use_imm), .a_out(a_out), .b_out(b_out), .stall(stall),
    .fwd_err(fwd_err));

  operand_fwd_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .FWD_EN(1'b0)) dut_nf (
    .clk(clk), .rst(rst), .adv(adv), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_is_load(wb_is_load), .ld_resp_valid(ld_resp_valid),
    .ld_resp_data(ld_resp_data), .rs1(rs1), .rs2(rs2), .rf_data_a(rf_data_a),
    .rf_data_b(rf_data_b), .pc(pc), .imm(imm), .a_use_pc(a_use_pc),
    .b_use_imm(b_use_imm), .a_out(a_out_nf), .b_out(b_out_nf), .stall(stall_nf),
    .fwd_err(fwd_err_nf));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hq.delete();
    for (int i = 0; i < DEPTH; i++) hq.push_back('0);
    m_err = 1'b0;
  endfunction

  // History as a youngest-first queue; the oldest pending load is filled before the shift.
  function automatic void model_update();
    ent_t e;
    if (rst) begin
      model_reset();
      return;
    end
    if (ld_resp_valid) begin
      for (int i = hq.size() - 1; i >= 0; i--) begin
        if (hq[i].pend) begin
          e = hq[i];
          e.data = ld_resp_data;
          e.pend = 1'b0;
          hq[i] = e;
          break;
        end
      end
    end
    if (adv) begin
      if (hq[hq.size()-1].pend) m_err = 1'b1;
      void'(hq.pop_back());
      e.vld  = wb_valid && (wb_rd != 0);
      e.rd   = wb_rd;
      e.data = wb_data;
      e.pend = e.vld && wb_is_load;
      hq.push_front(e);
    end
  endfunction

  function automatic void exp_op(input logic [4:0] rs, input logic use_alt,
                                 input logic [31:0] alt, input logic [31:0] rf,
                                 input bit fwd, output logic [31:0] o, output logic st);
    o  = use_alt ? alt : rf;
    st = 1'b0;
    if (!use_alt && rs != 0) begin
      for (int i = 0; i < hq.size(); i++) begin
        if (hq[i].vld && hq[i].rd == rs) begin
          if (!fwd || hq[i].pend) st = 1'b1;
          else o = hq[i].data;
          break;
        end
      end
    end
  endfunction

  task automatic eval();
    logic [31:0] ea, eb, ea_nf, eb_nf;
    logic sa, sb, sa_nf, sb_nf;
    #2;
    exp_op(rs1, a_use_pc,  pc,  rf_data_a, 1'b1, ea, sa);
    exp_op(rs2, b_use_imm, imm, rf_data_b, 1'b1, eb, sb);
    exp_op(rs1, a_use_pc,  pc,  rf_data_a, 1'b0, ea_nf, sa_nf);
    exp_op(rs2, b_use_imm, imm, rf_data_b, 1'b0, eb_nf, sb_nf);
    check("a_out", a_out, ea);
    check("b_out", b_out, eb);
    check("stall", {31'd0, stall}, {31'd0, sa | sb});
    check("a_out_nf", a_out_nf, ea_nf);
    check("b_out_nf", b_out_nf, eb_nf);
    check("stall_nf", {31'd0, stall_nf}, {31'd0, sa_nf | sb_nf});
    check("fwd_err", {31'd0, fwd_err}, {31'd0, m_err});
    check("fwd_err_nf", {31'd0, fwd_err_nf}, {31'd0, m_err});
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_push(input logic v, input logic [4:0] rd, input logic [31:0] d,
                          input logic ld);
    adv = 1'b1; wb_valid = v; wb_rd = rd; wb_data = d; wb_is_load = ld;
  endtask

  task automatic hold();
    adv = 1'b0; wb_valid = 1'b0; wb_is_load = 1'b0; ld_resp_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; adv = 0; wb_valid = 0; wb_rd = 0; wb_data = 0; wb_is_load = 0;
    ld_resp_valid = 0; ld_resp_data = 0; rs1 = 0; rs2 = 0; rf_data_a = 0;
    rf_data_b = 0; pc = 0; imm = 0; a_use_pc = 0; b_use_imm = 0;
    model_reset();
    clk_step();
    clk_step();
    rst = 1'b0;

    // Reset state: operands come straight from the register file.
    rs1 = 5; rf_data_a = 32'h11; rs2 = 6; rf_data_b = 32'h22;
    eval();
    check("rst_a_out", a_out, 32'h11);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fwd_err", {31'd0, fwd_err}, 32'd0);

    // Youngest of two matches wins; x0 is never forwarded.
    set_push(1, 5, 32'hAAAA, 0); eval(); clk_step();
    set_push(1, 5, 32'hBBBB, 0); eval(); clk_step();
    hold(); eval();
    check("youngest", a_out, 32'hBBBB);
    set_push(1, 0, 32'hCC, 0); clk_step();
    hold(); rs2 = 0; rf_data_b = 0; eval();
    check("x0_b_out", b_out, 32'h0);

    // Load-use stall, then fill during a bubble push.
    set_push(1, 7, 32'hDEAD, 1); clk_step();
    hold(); rs2 = 7; rf_data_b = 32'h77; eval();
    check("ld_use_stall", {31'd0, stall}, 32'd1);
    set_push(0, 0, 0, 0); ld_resp_valid = 1; ld_resp_data = 32'h1234; eval(); clk_step();
    hold(); eval();
    check("ld_fill_stall", {31'd0, stall}, 32'd0);
    check("ld_fill_b_out", b_out, 32'h1234);

    // Alternate operand sources suppress stall contributions.
    set_push(1, 11, 0, 1); clk_step();
    hold(); rs1 = 11; rs2 = 0; a_use_pc = 1; pc = 32'h1000; b_use_imm = 1; imm = 32'hABC;
    eval();
    check("pc_a_out", a_out, 32'h1000);
    check("pc_stall", {31'd0, stall}, 32'd0);
    check("imm_b_out", b_out, 32'hABC);
    a_use_pc = 0; b_use_imm = 0;
    ld_resp_valid = 1; ld_resp_data = 32'h5151; eval(); clk_step();
    hold(); eval();

    // A pending load ageing out sets the sticky error.
    set_push(1, 9, 0, 1); eval(); clk_step();
    for (int i = 0; i < DEPTH; i++) begin
      set_push(0, 0, 0, 0); eval(); clk_step();
    end
    hold(); eval();
    check("aging_err", {31'd0, fwd_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin set_push(0, 0, 0, 0); clk_step(); end
    hold(); eval();
    check("aging_sticky", {31'd0, fwd_err}, 32'd1);

    // Held history keeps forwarding while adv is low.
    set_push(1, 4, 32'h55, 0); clk_step();
    hold(); rs1 = 4; rf_data_a = 32'h99; rs2 = 0;
    for (int i = 0; i < 4; i++) begin
      eval();
      check("hold_fwd", a_out, 32'h55);
      check("nf_stall", {31'd0, stall_nf}, 32'd1);
      check("nf_a_out", a_out_nf, 32'h99);
      clk_step();
    end
    for (int i = 0; i < DEPTH; i++) begin set_push(0, 0, 0, 0); clk_step(); end
    hold(); eval();
    check("nf_clear", {31'd0, stall_nf}, 32'd0);

    // Randomised traffic against the model, with an occasional reset.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 199) == 0);
      adv           = ($urandom_range(0, 9) < 7);
      wb_valid      = ($urandom_range(0, 9) < 8);
      wb_rd         = 5'($urandom_range(0, 7));
      wb_data       = $urandom;
      wb_is_load    = ($urandom_range(0, 3) == 0);
      ld_resp_valid = ($urandom_range(0, 9) < 3);
      ld_resp_data  = $urandom;
      rs1           = 5'($urandom_range(0, 7));
      rs2           = 5'($urandom_range(0, 7));
      rf_data_a     = $urandom;
      rf_data_b     = $urandom;
      pc            = $urandom;
      imm           = $urandom;
      a_use_pc      = ($urandom_range(0, 4) == 0);
      b_use_imm     = ($urandom_range(0, 4) == 0);
      eval();
      clk_step();
    end

    // Reset clears the sticky error.
    hold(); rst = 1; clk_step(); rst = 0; eval();
    check("rst_clears_err", {31'd0, fwd_err}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
